// File: rtl/regfile_writeback_arbiter.sv
// rtl/regfile_writeback_arbiter.sv - merges ALU and queued LSU results onto the register file write port
module regfile_writeback_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDR_W-1:0]        lsu_addr,
    input  logic [DATA_W-1:0]        lsu_data,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_wda,
    output logic [DATA_W-1:0]        rf_wd,
    output logic [(2**ADDR_W)-1:0]   pending,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [DEPTH-1:0]             live_q, live_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]            rf_wda_q, rf_wda_d;
    logic [DATA_W-1:0]            rf_wd_q, rf_wd_d;
    logic [NREG-1:0]              pending_q, pending_d;

    logic alu_claim;
    logic enq;
    logic pop;

    assign lsu_ready = (count_q < DEPTH_C);

    always_comb begin
        alu_claim = alu_valid && (alu_addr != '0);
        enq       = lsu_valid && lsu_ready && (lsu_addr != '0);
        pop       = !alu_claim && (count_q != '0);

        addr_d   = addr_q;
        data_d   = data_q;
        live_d   = live_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rf_we_d  = 1'b0;
        rf_wda_d = rf_wda_q;
        rf_wd_d  = rf_wd_q;

        // The ALU result is younger than anything queued, so queued writes to the same register die.
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_claim && live_q[i] && (addr_q[i] == alu_addr)) begin
                live_d[i] = 1'b0;
            end
        end

        if (alu_claim) begin
            rf_we_d  = 1'b1;
            rf_wda_d = alu_addr;
            rf_wd_d  = alu_data;
        end else if (pop) begin
            if (live_q[rd_ptr_q]) begin
                rf_we_d  = 1'b1;
                rf_wda_d = addr_q[rd_ptr_q];
                rf_wd_d  = data_q[rd_ptr_q];
            end
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end

        // Enqueue after the kill so a same-cycle LSU result to the ALU's register stays live.
        if (enq) begin
            addr_d[wr_ptr_q] = lsu_addr;
            data_d[wr_ptr_q] = lsu_data;
            live_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(enq) - CNT_W'(pop);

        pending_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_d[i]) begin
                pending_d[addr_d[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            data_q    <= '0;
            live_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_wda_q  <= '0;
            rf_wd_q   <= '0;
            pending_q <= '0;
        end else begin
            addr_q    <= addr_d;
            data_q    <= data_d;
            live_q    <= live_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rf_we_q   <= rf_we_d;
            rf_wda_q  <= rf_wda_d;
            rf_wd_q   <= rf_wd_d;
            pending_q <= pending_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_wda     = rf_wda_q;
    assign rf_wd      = rf_wd_q;
    assign pending    = pending_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb/tb_regfile_writeback_arbiter.sv - directed and random checks of the writeback arbiter against a queue model
module tb_regfile_writeback_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_data;
    logic          rf_we;
    logic [AW-1:0] rf_wda;
    logic [DW-1:0] rf_wd;
    logic [31:0]   pending;
    logic [2:0]    fifo_count;

    regfile_writeback_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .rf_we(rf_we), .rf_wda(rf_wda), .rf_wd(rf_wd),
        .pending(pending), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            live;
    } ent_t;

    ent_t          q[$];
    logic          exp_we;
    logic [AW-1:0] exp_wda;
    logic [DW-1:0] exp_wd;
    logic [DW-1:0] shadow [32];
    logic [AW-1:0] order[$];
    bit            recording;
    int            vectors;
    int            miscompares;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (q[i]) if (q[i].live) p[q[i].addr] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_we  = 1'b0;
        exp_wda = '0;
        exp_wd  = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rf_we"}, 64'(rf_we), 64'(exp_we));
        check({tag, ".rf_wda"}, 64'(rf_wda), 64'(exp_wda));
        check({tag, ".rf_wd"}, 64'(rf_wd), 64'(exp_wd));
        check({tag, ".pending"}, 64'(pending), 64'(model_pending()));
        check({tag, ".fifo_count"}, 64'(fifo_count), 64'(q.size()));
    endtask

    // Called at a negedge: drive, cross one posedge updating the model, compare at the next negedge.
    task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                        output bit accepted);
        bit ready;
        bit claim;
        ent_t h;
        ent_t e;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        lsu_valid = lv; lsu_addr = la; lsu_data = ld;
        ready = (q.size() < DP);
        #1;
        check("lsu_ready", 64'(lsu_ready), 64'(ready));
        @(posedge clk);
        claim = av && (aa != 0);
        accepted = lv && ready;
        if (claim) begin
            exp_we = 1'b1; exp_wda = aa; exp_wd = ad;
            foreach (q[i]) if (q[i].addr == aa) q[i].live = 1'b0;
        end else if (q.size() > 0) begin
            h = q.pop_front();
            exp_we = h.live;
            if (h.live) begin exp_wda = h.addr; exp_wd = h.data; end
        end else begin
            exp_we = 1'b0;
        end
        if (accepted && la != 0) begin
            e.addr = la; e.data = ld; e.live = 1'b1;
            q.push_back(e);
        end
        @(negedge clk);
        check_outputs("step");
        if (rf_we) begin
            shadow[rf_wda] = rf_wd;
            if (recording) order.push_back(rf_wda);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, acc);
    endtask

    initial begin
        bit acc;
        int n_acc;
        int guard;
        logic [4:0] exp_addr;
        vectors = 0;
        miscompares = 0;
        recording = 0;
        reset = 1'b1;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
        foreach (shadow[i]) shadow[i] = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        check("reset.lsu_ready", 64'(lsu_ready), 64'd1);
        reset = 1'b0;

        // 1: ALU single-cycle write
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, acc);
        check("t1.we", 64'(rf_we), 64'd1);
        check("t1.wda", 64'(rf_wda), 64'd5);
        check("t1.wd", 64'(rf_wd), 64'hDEADBEEF);
        idle(1);
        check("t1.we_off", 64'(rf_we), 64'd0);

        // 2: LSU two-cycle latency, pending visible for one cycle
        step(0, 0, 0, 1, 7, 32'h11, acc);
        check("t2.pend7_set", 64'(pending[7]), 64'd1);
        check("t2.we_early", 64'(rf_we), 64'd0);
        idle(1);
        check("t2.we", 64'(rf_we), 64'd1);
        check("t2.wda", 64'(rf_wda), 64'd7);
        check("t2.pend7_clr", 64'(pending[7]), 64'd0);

        // 3: fill while ALU is busy, then drain in order
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            step(1, 20, $urandom, 1, 5'(n_acc + 1), 32'h100 + n_acc, acc);
            if (acc) n_acc++;
        end
        check("t3.accepts", 64'(n_acc), 64'd4);
        check("t3.full_ready", 64'(lsu_ready), 64'd0);
        recording = 1;
        guard = 0;
        while (n_acc < 5 && guard < 10) begin
            step(0, 0, 0, 1, 5, 32'h104, acc);
            if (acc) n_acc++;
            guard++;
        end
        check("t3.fifth_accepted", 64'(n_acc), 64'd5);
        idle(6);
        recording = 0;
        check("t3.drain_len", 64'(order.size()), 64'd5);
        for (int k = 0; k < 5 && k < order.size(); k++) begin
            exp_addr = 5'(k + 1);
            check("t3.order", 64'(order[k]), 64'(exp_addr));
        end

        // 4: ALU write kills a queued LSU result to the same register
        step(1, 10, 32'h0, 1, 9, 32'h99, acc);
        check("t4.pend9_set", 64'(pending[9]), 64'd1);
        step(1, 9, 32'hA5A5A5A5, 0, 0, 0, acc);
        check("t4.pend9_clr", 64'(pending[9]), 64'd0);
        check("t4.count_stale", 64'(fifo_count), 64'd1);
        idle(1);
        check("t4.stale_pop_no_we", 64'(rf_we), 64'd0);
        check("t4.rf9", 64'(shadow[9]), 64'hA5A5A5A5);

        // 5: register 0 is dropped on both paths
        step(1, 0, 32'h1234, 1, 0, 32'h5678, acc);
        check("t5.we", 64'(rf_we), 64'd0);
        check("t5.count", 64'(fifo_count), 64'd0);

        // 6: asynchronous reset with entries queued
        step(1, 20, 32'h1, 1, 11, 32'hB, acc);
        step(1, 20, 32'h2, 1, 12, 32'hC, acc);
        step(1, 20, 32'h3, 1, 13, 32'hD, acc);
        check("t6.count3", 64'(fifo_count), 64'd3);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("t6.async");
        check("t6.lsu_ready", 64'(lsu_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // random traffic with a narrow address range to provoke kills and register-0 drops
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, acc);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
